// File: rtl/muls_acc_x3y3.sv
// muls_acc_x3y3: frame accumulator for the signed 6-bit products of muls_x3y3.
// Sums FRAME_LEN valid products per frame. Each rising edge of in_rdy is
// accepted once. Products whose sign flag disagrees with their value raise a
// sticky error flag.
// Optional build macro MULS_ACC_SAT_EN: saturate the sum on overflow instead
// of letting it wrap.
`timescale 1ns/1ps
module muls_acc_x3y3 #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              in_p,
  input  logic                    in_s,
  input  logic                    in_rdy,
  input  logic                    clr,
  output logic signed [ACC_W-1:0] acc,
  output logic [3:0]              cnt,
  output logic                    done,
  output logic                    err,
  output logic                    ovf
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] FRAME_CNT = 4'(FRAME_LEN);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state;
  logic                    rdy_q;
  logic                    accept;
  logic                    valid;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc_next;
  logic [3:0]              cnt_next;
  logic                    add_ovf;

  // A product is taken only on the rising edge of the ready level.
  assign accept = in_rdy & ~rdy_q;

  // The sign flag must match the product MSB. A zero product is valid with either flag.
  assign valid = (in_s == in_p[5]) || (in_p == 6'd0);

  assign ext = ACC_W'($signed(in_p));

  // Next sum and count. A completed frame restarts from zero on its next product.
  always_comb begin
    base     = (state == DONE) ? '0 : acc;
    sum      = base + ext;
    add_ovf  = (base[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    acc_next = sum;
`ifdef MULS_ACC_SAT_EN
    if (add_ovf) begin
      acc_next = base[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
`else
`endif
    cnt_next = (state == DONE) ? 4'd1 : cnt + 4'd1;
  end

  // Frame state machine with registered outputs. clr beats any accepted product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy_q <= 1'b0;
      acc   <= '0;
      cnt   <= 4'd0;
      done  <= 1'b0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      rdy_q <= in_rdy;
      if (clr) begin
        state <= IDLE;
        acc   <= '0;
        cnt   <= 4'd0;
        done  <= 1'b0;
        err   <= 1'b0;
        ovf   <= 1'b0;
      end else if (accept) begin
        if (valid) begin
          acc <= acc_next;
          cnt <= cnt_next;
          if (add_ovf) begin
            ovf <= 1'b1;
          end
          if (cnt_next == FRAME_CNT) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= ACC;
            done  <= 1'b0;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_muls_acc_x3y3.sv
// Directed testbench for muls_acc_x3y3. Three instances share one stimulus:
// the default configuration, a 6-bit accumulator, and a one-product frame.
`timescale 1ns/1ps
module tb_muls_acc_x3y3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] in_p;
  logic       in_s;
  logic       in_rdy;
  logic       clr;

  logic signed [9:0] acc;
  logic [3:0]        cnt;
  logic              done, err, ovf;

  logic signed [5:0] acc6;
  logic [3:0]        cnt6;
  logic              done6, err6, ovf6;

  logic signed [9:0] acc1;
  logic [3:0]        cnt1;
  logic              done1, err1, ovf1;

  int n_vec = 0;
  int n_bad = 0;

`ifdef MULS_ACC_SAT_EN
  localparam logic [5:0] EXP_OVF6 = 6'b011111;
`else
  localparam logic [5:0] EXP_OVF6 = 6'b100000;
`endif

  muls_acc_x3y3 dut (
    .clk(clk), .rst_n(rst_n), .in_p(in_p), .in_s(in_s), .in_rdy(in_rdy), .clr(clr),
    .acc(acc), .cnt(cnt), .done(done), .err(err), .ovf(ovf)
  );

  muls_acc_x3y3 #(.FRAME_LEN(8), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_p(in_p), .in_s(in_s), .in_rdy(in_rdy), .clr(clr),
    .acc(acc6), .cnt(cnt6), .done(done6), .err(err6), .ovf(ovf6)
  );

  muls_acc_x3y3 #(.FRAME_LEN(1), .ACC_W(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_p(in_p), .in_s(in_s), .in_rdy(in_rdy), .clr(clr),
    .acc(acc1), .cnt(cnt1), .done(done1), .err(err1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  // Raise in_rdy for hold cycles, then drop it for one cycle.
  task automatic send(input logic [5:0] p, input logic s, input int hold);
    @(negedge clk);
    in_p = p; in_s = s; in_rdy = 1'b1;
    repeat (hold) @(negedge clk);
    in_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_p = 6'd0; in_s = 1'b0; in_rdy = 1'b0; clr = 1'b0;
    #12;
    n_vec++; if (acc !== 10'sd0) begin n_bad++; $display("FAIL reset_acc: got %0d expected 0", acc); end
    n_vec++; if (cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    n_vec++; if ({done, err, ovf} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {done, err, ovf}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    pulse_clr();
    for (int i = 0; i < 7; i++) send(6'd6, 1'b0, 2);
    n_vec++; if (cnt !== 4'd7) begin n_bad++; $display("FAIL frame_cnt7: got %0d expected 7", cnt); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL frame_done7: got %b expected 0", done); end
    @(negedge clk);
    in_p = 6'd6; in_s = 1'b0; in_rdy = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (done !== 1'b1) begin n_bad++; $display("FAIL frame_done_edge: got %b expected 1", done); end
    @(negedge clk); @(negedge clk);
    in_rdy = 1'b0;
    @(negedge clk);
    n_vec++; if (acc !== 10'sd48) begin n_bad++; $display("FAIL frame_acc: got %0d expected 48", acc); end
    n_vec++; if (cnt !== 4'd8) begin n_bad++; $display("FAIL frame_cnt: got %0d expected 8", cnt); end
    send(6'd2, 1'b0, 1);
    n_vec++; if (acc !== 10'sd2) begin n_bad++; $display("FAIL restart_acc: got %0d expected 2", acc); end
    n_vec++; if ({cnt, done} !== {4'd1, 1'b0}) begin n_bad++; $display("FAIL restart_cnt_done: got %0d/%b expected 1/0", cnt, done); end
  endtask

  task automatic test_signed();
    pulse_clr();
    send(6'b110100, 1'b1, 1);
    send(6'b010000, 1'b0, 1);
    n_vec++; if (acc !== 10'sd4) begin n_bad++; $display("FAIL signed_acc: got %0d expected 4", acc); end
    n_vec++; if ({cnt, done} !== {4'd2, 1'b0}) begin n_bad++; $display("FAIL signed_cnt_done: got %0d/%b expected 2/0", cnt, done); end
  endtask

  task automatic test_err();
    pulse_clr();
    send(6'd3, 1'b0, 1);
    send(6'd5, 1'b1, 1);
    n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b expected 1", err); end
    n_vec++; if ({acc, cnt} !== {10'sd3, 4'd1}) begin n_bad++; $display("FAIL err_hold: got %0d/%0d expected 3/1", acc, cnt); end
    send(6'd3, 1'b0, 1);
    n_vec++; if ({acc, cnt, err} !== {10'sd6, 4'd2, 1'b1}) begin n_bad++; $display("FAIL err_after: got %0d/%0d/%b expected 6/2/1", acc, cnt, err); end
    send(6'd0, 1'b1, 1);
    n_vec++; if ({acc, cnt} !== {10'sd6, 4'd3}) begin n_bad++; $display("FAIL zero_valid: got %0d/%0d expected 6/3", acc, cnt); end
    pulse_clr();
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clr: got %b expected 0", err); end
  endtask

  task automatic test_clr_drop();
    pulse_clr();
    send(6'd1, 1'b0, 1);
    @(negedge clk);
    in_p = 6'd7; in_s = 1'b0; in_rdy = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk); @(negedge clk);
    in_rdy = 1'b0;
    @(negedge clk);
    n_vec++; if ({acc, cnt, done} !== {10'sd0, 4'd0, 1'b0}) begin n_bad++; $display("FAIL clr_drop: got %0d/%0d/%b expected 0/0/0", acc, cnt, done); end
  endtask

  task automatic test_overflow();
    pulse_clr();
    send(6'd16, 1'b0, 1);
    send(6'd16, 1'b0, 1);
    n_vec++; if (acc6 !== EXP_OVF6) begin n_bad++; $display("FAIL ovf6_acc: got %0d expected %0d", acc6, $signed(EXP_OVF6)); end
    n_vec++; if (ovf6 !== 1'b1) begin n_bad++; $display("FAIL ovf6_flag: got %b expected 1", ovf6); end
    n_vec++; if ({acc, ovf} !== {10'sd32, 1'b0}) begin n_bad++; $display("FAIL ovf10: got %0d/%b expected 32/0", acc, ovf); end
    send(6'd1, 1'b0, 1);
    n_vec++; if (ovf6 !== 1'b1) begin n_bad++; $display("FAIL ovf6_sticky: got %b expected 1", ovf6); end
    pulse_clr();
    n_vec++; if (ovf6 !== 1'b0) begin n_bad++; $display("FAIL ovf6_clr: got %b expected 0", ovf6); end
  endtask

  task automatic test_frame1();
    pulse_clr();
    send(6'd3, 1'b0, 1);
    n_vec++; if ({acc1, cnt1, done1} !== {10'sd3, 4'd1, 1'b1}) begin n_bad++; $display("FAIL f1_first: got %0d/%0d/%b expected 3/1/1", acc1, cnt1, done1); end
    send(6'd4, 1'b0, 1);
    n_vec++; if ({acc1, cnt1, done1} !== {10'sd4, 4'd1, 1'b1}) begin n_bad++; $display("FAIL f1_second: got %0d/%0d/%b expected 4/1/1", acc1, cnt1, done1); end
  endtask

  task automatic test_async_reset();
    pulse_clr();
    for (int i = 0; i < 3; i++) send(6'd1, 1'b0, 1);
    n_vec++; if (cnt !== 4'd3) begin n_bad++; $display("FAIL pre_reset_cnt: got %0d expected 3", cnt); end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({acc, cnt, done, err, ovf} !== {10'sd0, 4'd0, 3'b000}) begin n_bad++; $display("FAIL async_reset: got %0d/%0d/%b expected 0/0/000", acc, cnt, {done, err, ovf}); end
    in_p = 6'd2; in_s = 1'b0; in_rdy = 1'b1;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({acc, cnt} !== {10'sd2, 4'd1}) begin n_bad++; $display("FAIL post_reset_accept: got %0d/%0d expected 2/1", acc, cnt); end
    @(negedge clk);
    in_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_signed();
    test_err();
    test_clr_drop();
    test_overflow();
    test_frame1();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/muls_acc_x3y3.md
MULS_ACC_X3Y3 -- requirements
Module: muls_acc_x3y3

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: products per frame, legal range 1..15.
REQ-002 SHALL have parameter ACC_W, default 10: accumulator width in bits, signed, legal range 6..16.
REQ-003 SHALL have port clk  in  1  sole clock, rising-edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_p  in  6  product from muls_x3y3, two's complement.
REQ-006 SHALL have port in_s  in  1  product sign flag from muls_x3y3.
REQ-007 SHALL have port in_rdy  in  1  product-ready level from muls_x3y3; may stay high for several cycles.
REQ-008 SHALL have port clr  in  1  synchronous frame clear.
REQ-009 SHALL have port acc  out  ACC_W  signed running sum, registered.
REQ-010 SHALL have port cnt  out  4  products accepted in the current frame, registered.
REQ-011 SHALL have port done  out  1  frame complete, registered level.
REQ-012 SHALL have port err  out  1  sticky sign-mismatch flag.
REQ-013 SHALL have port ovf  out  1  sticky accumulator-overflow flag.

Function
REQ-014 SHALL keep a registered copy rdy_q of in_rdy; a product is accepted only on a clk edge where in_rdy=1 and rdy_q=0, so each in_rdy assertion is accepted at most once.
REQ-015 SHALL treat a product as valid when in_s equals in_p[5], or when in_p=0 with in_s either value.
REQ-016 SHALL, on an accepted valid product, sign-extend in_p to ACC_W bits, add it to acc and increment cnt; results visible after that same edge (1-cycle latency).
REQ-017 SHALL, on an accepted invalid product, set err and leave acc, cnt, done unchanged.
REQ-018 SHALL implement states IDLE (cnt=0, done=0), ACC (0<cnt<FRAME_LEN) and DONE (cnt=FRAME_LEN, done=1).
REQ-019 SHALL transition IDLE->ACC on the first valid product, or IDLE->DONE on it when FRAME_LEN=1.
REQ-020 SHALL transition ACC->DONE on the edge that accepts the FRAME_LEN-th valid product, done rising on that edge.
REQ-021 SHALL, in DONE, hold acc and cnt; a valid product starts a new frame: acc=sign-extended in_p, cnt=1, done=0, state ACC (DONE if FRAME_LEN=1).
REQ-022 SHALL set ovf when a signed addition exceeds the ACC_W range; ovf stays set until clr or reset.
REQ-023 SHALL, on clr=1, set acc=0, cnt=0, done=0, err=0, ovf=0 and go to IDLE; clr wins over a simultaneous accepted product, which is dropped.
REQ-024 SHALL update rdy_q every cycle including clr cycles, so a product dropped by clr is not re-accepted while in_rdy stays high.

Reset
REQ-025 SHALL, while rst_n=0, force immediately and without clk: acc=0, cnt=0, done=0, err=0, ovf=0, rdy_q=0, state IDLE.
REQ-026 SHALL accept a product on the first clk edge after rst_n rises if in_rdy=1 there (rdy_q=0 from reset).
REQ-027 SHALL abandon any partial frame on reset; no state survives it.

Configuration
REQ-028 SHALL, with macro MULS_ACC_SAT_EN defined, clamp acc on overflow to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and set ovf.
REQ-029 SHALL, without MULS_ACC_SAT_EN, wrap acc modulo 2^ACC_W on overflow and set ovf.

Verification
REQ-030 Defaults, 8 products in_p=6, in_s=0, each in_rdy held 2 cycles -> acc=48, cnt=8, done=1 from the 8th accept edge; no double counting.
REQ-031 in_p=-12 (110100, s=1) then in_p=16 (010000, s=0) -> acc=4, cnt=2, done=0, state ACC.
REQ-032 in_p=5 with in_s=1 -> err=1, acc and cnt unchanged; following valid in_p=3 -> acc+=3, err stays 1 until clr.
REQ-033 clr=1 on the in_rdy rising edge with in_p=7, in_rdy then held high 3 cycles -> acc=0, cnt=0, done=0, product never accepted.
REQ-034 ACC_W=6, two products of 16 -> with MULS_ACC_SAT_EN acc=31, ovf=1; without it acc=-32, ovf=1.
REQ-035 rst_n pulsed low between clk edges after 3 products -> all outputs 0 before the next edge; next valid product gives cnt=1.
